// File: rtl/fft4_stream.sv
// fft4_stream: streaming 4-point radix-4 FFT/IFFT engine.
// Collects a 4-sample complex frame, computes all four bins in a single
// cycle, then drains them in natural order (bin 0..3), one per handshake.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   in_valid/in_ready   input sample handshake
//   in_data             {re, im}, each DW bits two's complement
//   inverse, scale      frame mode, captured with sample 0 only
//   out_valid/out_ready output bin handshake
//   out_data            bin {re, im}
//   out_idx             bin index of out_data
//   out_last            marks bin 3
module fft4_stream #(
  parameter int DW      = 32,
  parameter int SCALE_S = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2*DW-1:0] in_data,
  input  logic          inverse,
  input  logic          scale,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*DW-1:0] out_data,
  output logic [1:0]    out_idx,
  output logic          out_last
);

  localparam int SW = DW + 2;

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_DRAIN} state_t;

  state_t state_q, state_d;
  logic [1:0]      cnt_q;
  logic [1:0]      oidx_q;
  logic            inv_q;
  logic            scl_q;
  logic [2*DW-1:0] smp_q [4];
  logic [2*DW-1:0] res_q [4];
  logic [2*DW-1:0] res_d [4];
  logic            in_fire;
  logic            out_fire;

  logic signed [SW-1:0] xr [4];
  logic signed [SW-1:0] xi [4];
  logic signed [SW-1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;
  logic signed [SW-1:0] x1_re, x1_im, x3_re, x3_im;

  // Sign-extend one component into the DW+2 bit butterfly width.
  function automatic logic signed [SW-1:0] sext(input logic [DW-1:0] v);
    return {{2{v[DW-1]}}, v};
  endfunction

  // Optional arithmetic shift (truncates toward -inf), then wrap to DW bits.
  function automatic logic [DW-1:0] fin(input logic signed [SW-1:0] s,
                                        input logic sc);
    return sc ? DW'(s >>> SCALE_S) : DW'(s);
  endfunction

  assign in_fire  = in_ready && in_valid;
  assign out_fire = out_valid && out_ready;

  // Radix-4 butterfly on the buffered frame.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      xr[i] = sext(smp_q[i][2*DW-1:DW]);
      xi[i] = sext(smp_q[i][DW-1:0]);
    end
    a_re = xr[0] + xr[2];  a_im = xi[0] + xi[2];
    b_re = xr[0] - xr[2];  b_im = xi[0] - xi[2];
    c_re = xr[1] + xr[3];  c_im = xi[1] + xi[3];
    d_re = xr[1] - xr[3];  d_im = xi[1] - xi[3];
    // fwd X1 = B - jD, X3 = B + jD; inverse swaps the rotation direction.
    x1_re = inv_q ? (b_re - d_im) : (b_re + d_im);
    x1_im = inv_q ? (b_im + d_re) : (b_im - d_re);
    x3_re = inv_q ? (b_re + d_im) : (b_re - d_im);
    x3_im = inv_q ? (b_im - d_re) : (b_im + d_re);
    res_d[0] = {fin(a_re + c_re, scl_q), fin(a_im + c_im, scl_q)};
    res_d[1] = {fin(x1_re, scl_q), fin(x1_im, scl_q)};
    res_d[2] = {fin(a_re - c_re, scl_q), fin(a_im - c_im, scl_q)};
    res_d[3] = {fin(x3_re, scl_q), fin(x3_im, scl_q)};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (in_fire && cnt_q == 2'd3) state_d = S_CALC;
      S_CALC:  state_d = S_DRAIN;
      S_DRAIN: if (out_fire && oidx_q == 2'd3) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_LOAD);
    out_valid = (state_q == S_DRAIN);
    out_idx   = oidx_q;
    out_last  = out_valid && (oidx_q == 2'd3);
    out_data  = out_valid ? res_q[oidx_q] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      oidx_q  <= '0;
      inv_q   <= 1'b0;
      scl_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        smp_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        smp_q[cnt_q] <= in_data;
        cnt_q        <= cnt_q + 2'd1;  // wraps 3 -> 0 at frame end
        if (cnt_q == 2'd0) begin
          inv_q <= inverse;
          scl_q <= scale;
        end
      end
      if (state_q == S_CALC) begin
        for (int i = 0; i < 4; i++) res_q[i] <= res_d[i];
      end
      if (out_fire) oidx_q <= oidx_q + 2'd1;
    end
  end

endmodule
